// File: rtl/tx_gear_pkg.sv
// Shared types and constants for the Tx 125->250 MHz gearbox sequencer.
package tx_gear_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    FILL      = 3'd2,
    ACTIVE    = 3'd3,
    DRAIN     = 3'd4
  } txg_state_e;

  localparam int TXG_MIN_FILL = 8;
  localparam logic [9:0] TXG_EI_WORD = 10'h200;

  function automatic int txg_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tx_gear_sync2.sv
// Two-flop synchroniser for a single asynchronous level, reset to 0.
module tx_gear_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/tx_gear_seq.sv
// Tx gearbox sequencer: orders gear_en / ei_force / tx_ready around PLL lock.
// Optional lock timeout enabled by defining TX_GEAR_SEQ_TIMEOUT_EN.
module tx_gear_seq
  import tx_gear_pkg::*;
#(
  parameter int FILL_CYC  = 8,
  parameter int DRAIN_CYC = 4,
  parameter int TMO_W     = 12
) (
  input  logic clk_250,
  input  logic rst_n,
  input  logic tx_en_req,
  input  logic pll_lock,
  output logic gear_en,
  output logic ei_force,
  output logic tx_ready,
`ifdef TX_GEAR_SEQ_TIMEOUT_EN
  output logic lock_err,
`endif
  output logic busy
);

  // A fill shorter than the gearbox depth would expose stale RAM, so clamp it.
  localparam int FILL_EFF = (FILL_CYC < TXG_MIN_FILL) ? TXG_MIN_FILL : FILL_CYC;
  localparam int CNT_W    = $clog2(txg_max(FILL_EFF, DRAIN_CYC)) + 1;
  localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_EFF - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  logic       en_s;
  logic       lock_s;
  txg_state_e state_r;
  txg_state_e state_nx;
  logic [CNT_W-1:0] cnt_r;
  logic       tmo_hit_s;
  logic       blk_s;

  tx_gear_sync2 u_sync_en (
    .clk   (clk_250),
    .rst_n (rst_n),
    .d     (tx_en_req),
    .q     (en_s)
  );

  tx_gear_sync2 u_sync_lock (
    .clk   (clk_250),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

`ifdef TX_GEAR_SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_r;
  logic             en_d_r;
  logic             blk_r;
  logic             lock_err_r;

  assign tmo_hit_s = (state_r == WAIT_LOCK) && en_s && !lock_s && (tmo_r == {TMO_W{1'b1}});
  assign blk_s     = blk_r;

  // Lock timer, sticky error flag and re-arm gating after a timeout
  always_ff @(posedge clk_250 or negedge rst_n) begin
    if (!rst_n) begin
      tmo_r      <= {TMO_W{1'b0}};
      en_d_r     <= 1'b0;
      blk_r      <= 1'b0;
      lock_err_r <= 1'b0;
    end else begin
      en_d_r <= en_s;
      if ((state_r == WAIT_LOCK) && (state_nx == WAIT_LOCK) && (tmo_r != {TMO_W{1'b1}})) begin
        tmo_r <= tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
      end else if (state_nx != WAIT_LOCK) begin
        tmo_r <= {TMO_W{1'b0}};
      end else begin
        tmo_r <= tmo_r;
      end
      if (tmo_hit_s) begin
        blk_r <= 1'b1;
      end else if (!en_s) begin
        blk_r <= 1'b0;
      end else begin
        blk_r <= blk_r;
      end
      if (tmo_hit_s) begin
        lock_err_r <= 1'b1;
      end else if (en_s && !en_d_r) begin
        lock_err_r <= 1'b0;
      end else begin
        lock_err_r <= lock_err_r;
      end
    end
  end

  assign lock_err = lock_err_r;
`else
  assign tmo_hit_s = 1'b0;
  assign blk_s     = 1'b0;
`endif

  // Next-state logic; lock loss outranks enable removal
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (en_s && !blk_s) state_nx = WAIT_LOCK;
        else                state_nx = IDLE;
      end
      WAIT_LOCK: begin
        if (!en_s)          state_nx = IDLE;
        else if (lock_s)    state_nx = FILL;
        else if (tmo_hit_s) state_nx = IDLE;
        else                state_nx = WAIT_LOCK;
      end
      FILL: begin
        if (!lock_s)                 state_nx = WAIT_LOCK;
        else if (!en_s)              state_nx = DRAIN;
        else if (cnt_r == FILL_LAST) state_nx = ACTIVE;
        else                         state_nx = FILL;
      end
      ACTIVE: begin
        if (!lock_s)     state_nx = WAIT_LOCK;
        else if (!en_s)  state_nx = DRAIN;
        else             state_nx = ACTIVE;
      end
      DRAIN: begin
        if (cnt_r == DRAIN_LAST) state_nx = IDLE;
        else                     state_nx = DRAIN;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register and saturating dwell counter, cleared on every state entry
  always_ff @(posedge clk_250 or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nx;
      if (state_nx != state_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Outputs registered from the next state so they change on the transition edge
  always_ff @(posedge clk_250 or negedge rst_n) begin
    if (!rst_n) begin
      gear_en  <= 1'b0;
      ei_force <= 1'b1;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state_nx)
        IDLE:      begin gear_en <= 1'b0; ei_force <= 1'b1; tx_ready <= 1'b0; busy <= 1'b0; end
        WAIT_LOCK: begin gear_en <= 1'b0; ei_force <= 1'b1; tx_ready <= 1'b0; busy <= 1'b1; end
        FILL:      begin gear_en <= 1'b1; ei_force <= 1'b1; tx_ready <= 1'b0; busy <= 1'b1; end
        ACTIVE:    begin gear_en <= 1'b1; ei_force <= 1'b0; tx_ready <= 1'b1; busy <= 1'b0; end
        DRAIN:     begin gear_en <= 1'b1; ei_force <= 1'b1; tx_ready <= 1'b0; busy <= 1'b1; end
        default:   begin gear_en <= 1'b0; ei_force <= 1'b1; tx_ready <= 1'b0; busy <= 1'b0; end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_gear_seq.sv
// Directed table-driven bench for tx_gear_seq (default FILL_CYC=8, DRAIN_CYC=4).
module tb_tx_gear_seq;

  logic clk_250 = 1'b0;
  logic rst_n;
  logic tx_en_req;
  logic pll_lock;
  logic gear_en;
  logic ei_force;
  logic tx_ready;
  logic busy;
`ifdef TX_GEAR_SEQ_TIMEOUT_EN
  logic lock_err;
`endif

  int checks = 0;
  int errors = 0;

  always #2 clk_250 = ~clk_250;

`ifdef TX_GEAR_SEQ_TIMEOUT_EN
  tx_gear_seq #(.FILL_CYC(8), .DRAIN_CYC(4), .TMO_W(4)) dut (
    .clk_250(clk_250), .rst_n(rst_n), .tx_en_req(tx_en_req), .pll_lock(pll_lock),
    .gear_en(gear_en), .ei_force(ei_force), .tx_ready(tx_ready),
    .lock_err(lock_err), .busy(busy)
  );
`else
  tx_gear_seq #(.FILL_CYC(8), .DRAIN_CYC(4), .TMO_W(12)) dut (
    .clk_250(clk_250), .rst_n(rst_n), .tx_en_req(tx_en_req), .pll_lock(pll_lock),
    .gear_en(gear_en), .ei_force(ei_force), .tx_ready(tx_ready), .busy(busy)
  );
`endif

  typedef struct {
    string tag;
    logic  en;
    logic  lock;
    int    cyc;
    logic  g;
    logic  e;
    logic  r;
    logic  b;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic g, input logic e, input logic r, input logic b);
    chk({tag, ".gear_en"},  gear_en,  g);
    chk({tag, ".ei_force"}, ei_force, e);
    chk({tag, ".tx_ready"}, tx_ready, r);
    chk({tag, ".busy"},     busy,     b);
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic adv(input int n);
    repeat (n) @(posedge clk_250);
    #1;
  endtask

  initial begin
    int waited;
    rst_n     = 1'b0;
    tx_en_req = 1'b0;
`ifdef TX_GEAR_SEQ_TIMEOUT_EN
    pll_lock  = 1'b0;
`else
    pll_lock  = 1'b1;
`endif
    #7;
    chk_out("reset", 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef TX_GEAR_SEQ_TIMEOUT_EN
    chk("reset.lock_err", lock_err, 1'b0);
`endif
    @(negedge clk_250);
    rst_n = 1'b1;
    adv(3);
    chk_out("post_reset_idle", 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef TX_GEAR_SEQ_TIMEOUT_EN
    // WAIT_LOCK entered at edge 3, timer hits 15 at edge 18, exits on edge 19.
    tx_en_req = 1'b1;
    adv(18);
    chk("tmo.pre_err", lock_err, 1'b0);
    chk("tmo.pre_busy", busy, 1'b1);
    adv(1);
    chk("tmo.err_set", lock_err, 1'b1);
    chk_out("tmo.idle", 1'b0, 1'b1, 1'b0, 1'b0);
    adv(5);
    chk("tmo.sticky", lock_err, 1'b1);
    chk("tmo.no_rearm", busy, 1'b0);
    tx_en_req = 1'b0;
    adv(4);
    tx_en_req = 1'b1;
    adv(3);
    chk("tmo.err_clr", lock_err, 1'b0);
    chk("tmo.rearm_busy", busy, 1'b1);
    pll_lock = 1'b1;
    adv(3);
    chk("tmo.fill_gear", gear_en, 1'b1);
`else
    // Cycle counts measured from the input change (2 sync flops + FSM edge).
    vq.push_back('{"up_wait",     1'b1, 1'b1, 3,  1'b0, 1'b1, 1'b0, 1'b1});
    vq.push_back('{"up_gear",     1'b1, 1'b1, 1,  1'b1, 1'b1, 1'b0, 1'b1});
    vq.push_back('{"up_fill7",    1'b1, 1'b1, 7,  1'b1, 1'b1, 1'b0, 1'b1});
    vq.push_back('{"up_ready",    1'b1, 1'b1, 1,  1'b1, 1'b0, 1'b1, 1'b0});
    vq.push_back('{"active_hold", 1'b1, 1'b1, 5,  1'b1, 1'b0, 1'b1, 1'b0});
    vq.push_back('{"dn_drain",    1'b0, 1'b1, 3,  1'b1, 1'b1, 1'b0, 1'b1});
    vq.push_back('{"dn_drain3",   1'b0, 1'b1, 3,  1'b1, 1'b1, 1'b0, 1'b1});
    vq.push_back('{"dn_idle",     1'b0, 1'b1, 1,  1'b0, 1'b1, 1'b0, 1'b0});
    vq.push_back('{"re_active",   1'b1, 1'b1, 12, 1'b1, 1'b0, 1'b1, 1'b0});
    vq.push_back('{"ll_wait",     1'b1, 1'b0, 3,  1'b0, 1'b1, 1'b0, 1'b1});
    vq.push_back('{"ll_sync",     1'b1, 1'b1, 2,  1'b0, 1'b1, 1'b0, 1'b1});
    vq.push_back('{"ll_fill",     1'b1, 1'b1, 1,  1'b1, 1'b1, 1'b0, 1'b1});
    vq.push_back('{"ll_fill7",    1'b1, 1'b1, 7,  1'b1, 1'b1, 1'b0, 1'b1});
    vq.push_back('{"ll_ready",    1'b1, 1'b1, 1,  1'b1, 1'b0, 1'b1, 1'b0});
    vq.push_back('{"off_drain",   1'b0, 1'b1, 3,  1'b1, 1'b1, 1'b0, 1'b1});
    vq.push_back('{"off_idle",    1'b0, 1'b1, 4,  1'b0, 1'b1, 1'b0, 1'b0});
    vq.push_back('{"nolock_50",   1'b1, 1'b0, 50, 1'b0, 1'b1, 1'b0, 1'b1});
    vq.push_back('{"nolock_sync", 1'b1, 1'b1, 2,  1'b0, 1'b1, 1'b0, 1'b1});
    vq.push_back('{"nolock_gear", 1'b1, 1'b1, 1,  1'b1, 1'b1, 1'b0, 1'b1});
    vq.push_back('{"nolock_rdy",  1'b1, 1'b1, 8,  1'b1, 1'b0, 1'b1, 1'b0});
    vq.push_back('{"both_wait",   1'b0, 1'b0, 3,  1'b0, 1'b1, 1'b0, 1'b1});
    vq.push_back('{"both_idle",   1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0});
    vq.push_back('{"relock_idle", 1'b0, 1'b1, 3,  1'b0, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < vq.size(); i++) begin
      tx_en_req = vq[i].en;
      pll_lock  = vq[i].lock;
      adv(vq[i].cyc);
      chk_out(vq[i].tag, vq[i].g, vq[i].e, vq[i].r, vq[i].b);
    end
`endif

    // Reset in the middle of FILL: outputs must drop without a clock edge.
    tx_en_req = 1'b1;
    pll_lock  = 1'b1;
    waited = 0;
    while ((gear_en !== 1'b1) && (waited < 20)) begin
      adv(1);
      waited++;
    end
    chk("midfill.reached", gear_en, 1'b1);
    adv(2);
    chk("midfill.not_ready", tx_ready, 1'b0);
    #1;
    rst_n = 1'b0;
    #0.5;
    chk_out("midfill.async_rst", 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk_250);
    rst_n = 1'b1;
    adv(1);
    chk_out("midfill.idle", 1'b0, 1'b1, 1'b0, 1'b0);
    adv(2);
    chk_out("midfill.wait", 1'b0, 1'b1, 1'b0, 1'b1);
    adv(1);
    chk_out("midfill.refill", 1'b1, 1'b1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
